muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Iterative sequencer for RV32M multiply/divide, sitting beside the single-cycle ALU in the execute stage.
- Accepts one operation per valid/ready handshake and runs a radix-2 shift-add or restoring-divide loop.
- Holds the result until the write-back side accepts it; the controller stalls the pipeline while busy is high.
- Handles RISC-V divide-by-zero and signed-overflow cases on a short fixed path.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 5, iteration counter width (log2 XLEN).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_op  in  3  muldiv_op_t (funct3 encoding)
- req_a  in  XLEN  rs1 operand
- req_b  in  XLEN  rs2 operand
- kill  in  1  flush: abort the in-flight operation
- resp_valid  out  1  result available
- resp_ready  in  1  write-back accepts the result
- resp_data  out  XLEN  result
- busy  out  1  operation accepted and not yet retired

Behaviour:
- Reset (async, rst_n=0): state IDLE, req_ready=1, resp_valid=0, busy=0, resp_data=0, counter=0.
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE: req_ready=1. On req_valid&req_ready at edge T0, latch op/a/b and go to PREP. busy=1 from T0+1.
- PREP (1 cycle):
  - Compute absolute values per op signedness (MULH: both signed; MULHSU: a signed, b unsigned; MULHU/DIVU/REMU: unsigned).
  - Record result sign.
  - Detect specials:
    - div/rem with b==0: DIV/DIVU -> all ones; REM/REMU -> a.
    - DIV with a==0x80000000, b==-1 -> 0x80000000; REM -> 0.
  - Special case: load the result and go to DONE. resp_valid=1 at T0+2.
  - Otherwise: counter=0, go to CALC.
- CALC (XLEN cycles): one iteration per cycle. Counter increments and wraps at XLEN-1 into FIX.
  - Multiply: 2*XLEN-bit accumulator.
  - Divide: restoring, XLEN-bit quotient and remainder.
- FIX (1 cycle): apply sign correction, select result, go to DONE.
  - Result selection: low product for MUL; high product for MULH*; quotient for DIV*; remainder for REM*.
  - Remainder takes the sign of the dividend.
  - Normal latency: resp_valid=1 at T0+XLEN+3 (35 for XLEN=32).
- DONE: resp_valid=1 and resp_data stable until resp_valid&resp_ready.
  - On handshake go to IDLE; req_ready=1 the next cycle.
  - No back-to-back accept in the same cycle as retirement.
- req_ready=1 only in IDLE. req_valid outside IDLE is ignored (no latch).
- kill:
  - In PREP/CALC/FIX/DONE: go to IDLE next edge, resp_valid=0, busy=0, no response issued.
  - In IDLE: kill has priority over a simultaneous req_valid; nothing is accepted.
- busy = state!=IDLE.
- resp_data retains its last value in IDLE (not cleared).
- All arithmetic is modulo 2^XLEN or 2^(2*XLEN). Signed operands are two's complement.
- Reset asserted mid-operation: immediate return to reset values; the in-flight op is lost.

Decomposition:
- Package muldiv_op_pkg:
  - muldiv_op_t enum (MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7).
  - State enum muldiv_state_t.
  - XLEN-derived constants: MIN_INT, ALL_ONES.
- One sub-module, muldiv_step: combinational single iteration.
  - Inputs: mode, accumulator/remainder, operand.
  - Outputs: next accumulator/remainder and quotient bit.
  - muldiv_seq owns the FSM, counter, registers and handshakes.

Test Plan:
- MUL a=7, b=0xFFFFFFFD -> resp_data=0xFFFFFFEB; resp_valid exactly 35 cycles after accept; busy high throughout.
- MULH a=0x80000000, b=0x80000000 -> 0x40000000. MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU a=5, b=0 -> 0xFFFFFFFF and REM a=5, b=0 -> 5, each resp_valid 2 cycles after accept. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
- Backpressure: hold resp_ready=0 for 10 cycles in DONE -> resp_valid and resp_data stable, req_ready=0. Then release -> IDLE, req_ready=1 the next cycle.
- kill asserted at CALC iteration 10 -> IDLE next cycle, no resp_valid, busy=0. A new MUL 3*4 then returns 12. rst_n pulsed mid-CALC -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/muldiv_op_pkg.sv
// Shared types and constants for the RV32M iterative multiply/divide unit.
package muldiv_op_pkg;

  localparam int unsigned MULDIV_XLEN = 32;

  // funct3 encoding of the M-extension operations
  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_CALC = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } muldiv_state_t;

  localparam logic [MULDIV_XLEN-1:0] MIN_INT  = {1'b1, {(MULDIV_XLEN-1){1'b0}}};
  localparam logic [MULDIV_XLEN-1:0] ALL_ONES = {MULDIV_XLEN{1'b1}};

  function automatic logic op_is_div(input muldiv_op_t op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide on a double-width accumulator.
module muldiv_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic              div_mode,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   operand,
  output logic [2*XLEN-1:0] acc_nxt,
  output logic              q_bit
);

  logic [XLEN:0] add_sum;
  logic [XLEN:0] trial;

  always_comb begin
    add_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});
    // Remainder shifted left by one with the next dividend bit, minus the divisor
    trial   = acc[2*XLEN-1:XLEN-1] - {1'b0, operand};
    q_bit   = 1'b0;
    acc_nxt = {add_sum, acc[XLEN-1:1]};
    if (div_mode) begin
      q_bit   = ~trial[XLEN];
      acc_nxt = {(q_bit ? trial[XLEN-1:0] : acc[2*XLEN-2:XLEN-1]), acc[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer with valid/ready request and response handshakes.
module muldiv_seq
  import muldiv_op_pkg::*;
#(
  parameter int unsigned XLEN  = MULDIV_XLEN,
  parameter int unsigned CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  muldiv_op_t      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic            kill,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            busy
);

  muldiv_state_t     state_q, state_nxt;
  muldiv_op_t        op_q;
  logic [XLEN-1:0]   a_q, b_q, opnd_q;
  logic [2*XLEN-1:0] acc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              neg_q, rneg_q;

  logic              a_sgn, b_sgn, div_zero, div_ovf, special;
  logic [XLEN-1:0]   abs_a, abs_b, special_res, fix_res;
  logic [2*XLEN-1:0] prod, step_acc;
  logic [XLEN-1:0]   quo, rem;
  logic              step_q;
  logic              last_iter;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .div_mode (op_is_div(op_q)),
    .acc      (acc_q),
    .operand  (opnd_q),
    .acc_nxt  (step_acc),
    .q_bit    (step_q)
  );

  // Operand conditioning and special-case detection for the PREP cycle
  always_comb begin
    a_sgn    = a_q[XLEN-1] & (op_q inside {MULH, MULHSU, DIV, REM});
    b_sgn    = b_q[XLEN-1] & (op_q inside {MULH, DIV, REM});
    abs_a    = a_sgn ? -a_q : a_q;
    abs_b    = b_sgn ? -b_q : b_q;
    div_zero = op_is_div(op_q) && (b_q == '0);
    div_ovf  = (op_q inside {DIV, REM}) && (a_q == MIN_INT) && (b_q == ALL_ONES);
    special  = div_zero | div_ovf;
    if (div_zero) special_res = op_q[1] ? a_q : ALL_ONES;
    else          special_res = op_q[1] ? '0 : MIN_INT;
  end

  // Sign correction and result selection for the FIX cycle
  always_comb begin
    prod = neg_q  ? -acc_q : acc_q;
    quo  = neg_q  ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem  = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    unique case (op_q)
      MUL:                  fix_res = acc_q[XLEN-1:0];
      MULH, MULHSU, MULHU:  fix_res = prod[2*XLEN-1:XLEN];
      DIV, DIVU:            fix_res = quo;
      default:              fix_res = rem;
    endcase
  end

  assign last_iter = (cnt_q == CNT_W'(XLEN-1));

  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      ST_IDLE: if (!kill && req_valid) state_nxt = ST_PREP;
      ST_PREP: state_nxt = kill ? ST_IDLE : (special ? ST_DONE : ST_CALC);
      ST_CALC: if (kill) state_nxt = ST_IDLE;
               else if (last_iter) state_nxt = ST_FIX;
      ST_FIX:  state_nxt = kill ? ST_IDLE : ST_DONE;
      ST_DONE: if (kill || resp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      busy       <= 1'b0;
      resp_data  <= '0;
      op_q       <= MUL;
      a_q        <= '0;
      b_q        <= '0;
      opnd_q     <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      neg_q      <= 1'b0;
      rneg_q     <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      req_ready  <= (state_nxt == ST_IDLE);
      resp_valid <= (state_nxt == ST_DONE);
      busy       <= (state_nxt != ST_IDLE);
      unique case (state_q)
        ST_IDLE: if (state_nxt == ST_PREP) begin
          op_q <= req_op;
          a_q  <= req_a;
          b_q  <= req_b;
        end
        ST_PREP: begin
          acc_q  <= {{XLEN{1'b0}}, abs_a};
          opnd_q <= abs_b;
          neg_q  <= a_sgn ^ b_sgn;
          rneg_q <= a_sgn;
          cnt_q  <= '0;
          if (state_nxt == ST_DONE) resp_data <= special_res;
        end
        ST_CALC: begin
          acc_q <= {step_acc[2*XLEN-1:1], step_acc[0] | step_q};
          cnt_q <= last_iter ? '0 : cnt_q + CNT_W'(1);
        end
        ST_FIX: if (state_nxt == ST_DONE) resp_data <= fix_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed RV32M cases, handshake corners and random ops vs. an arithmetic model.
module tb_muldiv_seq;
  import muldiv_op_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, kill, resp_valid, resp_ready, busy;
  muldiv_op_t  req_op;
  logic [31:0] req_a, req_b, resp_data;

  int n_cmp = 0;
  int n_err = 0;

  muldiv_seq dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .kill(kill),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // RISC-V M-extension semantics computed with 64-bit integer arithmetic
  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa = longint'($signed(a));
    longint      sb = longint'($signed(b));
    longint      ua = longint'({32'b0, a});
    longint      ub = longint'({32'b0, b});
    logic [63:0] p;
    int          ia = $signed(a);
    int          ib = $signed(b);
    case (op)
      3'd0: begin p = 64'(ua * ub); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!op[2]) return 1'b0;
    if (b == 0) return 1'b1;
    return (op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  // Issue one op, measure latency, optionally stall the response, then retire it
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int rdly);
    logic [31:0] exp_d;
    int          exp_lat, lat;
    bit          seen, busy_ok;
    exp_d   = ref_res(op, a, b);
    exp_lat = is_special(op, a, b) ? 2 : 35;
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_op = muldiv_op_t'(op); req_a = a; req_b = b; req_valid = 1'b1;
    @(posedge clk);
    lat = 0; seen = 1'b0; busy_ok = 1'b1;
    while (!seen && lat < 100) begin
      @(negedge clk);
      req_valid = 1'b0;
      lat++;
      if (!busy) busy_ok = 1'b0;
      if (resp_valid) seen = 1'b1;
    end
    chk("resp_seen", 32'(seen), 32'd1);
    chk("busy_held", 32'(busy_ok), 32'd1);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("resp_data", resp_data, exp_d);
    for (int i = 0; i < rdly; i++) begin
      req_valid = 1'b1; req_op = muldiv_op_t'(3'($urandom)); req_a = $urandom; req_b = $urandom;
      @(negedge clk);
      chk("stall_valid", 32'(resp_valid), 32'd1);
      chk("stall_data", resp_data, exp_d);
      chk("stall_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    chk("retire_valid", 32'(resp_valid), 32'd0);
    chk("retire_req_ready", 32'(req_ready), 32'd1);
    chk("retire_busy", 32'(busy), 32'd0);
    chk("retained_data", resp_data, exp_d);
  endtask

  logic [2:0]  d_op [14] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6, 3'd7, 3'd4};
  logic [31:0] d_a  [14] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                             32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd9, 32'd0};
  logic [31:0] d_b  [14] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2,
                             32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
  logic [31:0] pick [4]  = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1};

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; kill = 1'b0; resp_ready = 1'b0;
    req_op = MUL; req_a = '0; req_b = '0;
    #12;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Spot-check expected constants from the test plan against the model
    chk("plan_mul", ref_res(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);

    for (int i = 0; i < 14; i++) run_op(d_op[i], d_a[i], d_b[i], (i == 0) ? 10 : 0);

    // kill in IDLE has priority over a request
    @(negedge clk);
    req_op = MUL; req_a = 32'd5; req_b = 32'd5; req_valid = 1'b1; kill = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; kill = 1'b0;
    chk("idle_kill_busy", 32'(busy), 32'd0);
    chk("idle_kill_ready", 32'(req_ready), 32'd1);

    // kill during CALC iteration 10
    req_op = DIVU; req_a = 32'd1000; req_b = 32'd3; req_valid = 1'b1;
    @(posedge clk);
    repeat (11) begin @(negedge clk); req_valid = 1'b0; end
    chk("calc_busy", 32'(busy), 32'd1);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill_busy", 32'(busy), 32'd0);
    chk("kill_resp_valid", 32'(resp_valid), 32'd0);
    chk("kill_req_ready", 32'(req_ready), 32'd1);
    begin
      bit late_resp = 1'b0;
      repeat (40) begin @(negedge clk); if (resp_valid) late_resp = 1'b1; end
      chk("kill_no_resp", 32'(late_resp), 32'd0);
    end
    run_op(3'd0, 32'd3, 32'd4, 0);

    // Async reset mid-CALC
    @(negedge clk);
    req_op = MULHU; req_a = 32'hDEAD_BEEF; req_b = 32'h1234_5678; req_valid = 1'b1;
    @(posedge clk);
    repeat (6) begin @(negedge clk); req_valid = 1'b0; end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req_ready", 32'(req_ready), 32'd1);
    chk("arst_resp_valid", 32'(resp_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_resp_data", resp_data, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra, rb;
      ra = ($urandom_range(0, 4) == 0) ? pick[$urandom_range(0, 3)] : $urandom;
      rb = ($urandom_range(0, 4) == 0) ? pick[$urandom_range(0, 3)] : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(8, 31);
      run_op(3'($urandom_range(0, 7)), ra, rb, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
